// File: rtl/issue_dispatch_queue.sv
// Two-wide in-order issue queue: dual enqueue into a circular buffer, single dispatch to a free class-matched RS.
// Optional IQ_STALL_CNT_EN adds a saturating head-stall cycle counter (STALL_CNT).
module issue_dispatch_queue #(
    parameter int TASK_W = 64,
    parameter int DEPTH  = 16,
    parameter int N_RS   = 2
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        FLUSH,
    input  logic [1:0]                  ENQ_VALID,
    input  logic [TASK_W-1:0]           ENQ_TASK_0,
    input  logic [TASK_W-1:0]           ENQ_TASK_1,
    input  logic [1:0]                  ENQ_CLASS_0,
    input  logic [1:0]                  ENQ_CLASS_1,
    output logic                        ENQ_READY,
    input  logic [3*N_RS-1:0]           RS_BUSY,
    output logic                        DISP_VALID,
    output logic [TASK_W-1:0]           DISP_TASK,
    output logic [$clog2(3*N_RS)-1:0]   DISP_RS,
    output logic [$clog2(DEPTH+1)-1:0]  COUNT,
    output logic                        FULL
`ifdef IQ_STALL_CNT_EN
    ,
    output logic [31:0]                 STALL_CNT
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int N_TOT = 3*N_RS;
    localparam int RS_W  = $clog2(N_TOT);

    typedef enum logic [1:0] {
        CLS_ALU   = 2'd0,
        CLS_LOAD  = 2'd1,
        CLS_STORE = 2'd2
    } cls_e;

    logic [TASK_W-1:0] task_mem [DEPTH];
    cls_e              cls_mem  [DEPTH];

    logic [PTR_W-1:0]  head, tail, wr_ptr1;
    logic [N_TOT-1:0]  resv_mask;
    logic              enq_fire;
    logic [1:0]        enq_n;
    logic              disp_ok;
    logic [RS_W-1:0]   disp_idx;
    logic [RS_W-1:0]   rs_probe;
    logic [CNT_W-1:0]  count_next;
    cls_e              head_cls;

    function automatic cls_e to_cls(input logic [1:0] c);
        return (c == 2'd3) ? CLS_ALU : cls_e'(c);
    endfunction

    assign ENQ_READY  = (COUNT <= CNT_W'(DEPTH - 2));
    assign enq_fire   = ENQ_READY && (ENQ_VALID != 2'b00);
    assign enq_n      = enq_fire ? ({1'b0, ENQ_VALID[0]} + {1'b0, ENQ_VALID[1]}) : 2'd0;
    assign wr_ptr1    = tail + PTR_W'(ENQ_VALID[0]);
    assign head_cls   = cls_mem[head];
    assign count_next = COUNT + CNT_W'(enq_n) - CNT_W'(disp_ok);

    // Lowest free RS in the head's class, skipping the one dispatched last cycle
    // because its busy bit may not have risen yet.
    always_comb begin
        disp_ok  = 1'b0;
        disp_idx = '0;
        rs_probe = '0;
        for (int unsigned i = 0; i < N_RS; i++) begin
            rs_probe = RS_W'(32'(head_cls) * N_RS + i);
            if ((COUNT != '0) && !disp_ok && !RS_BUSY[rs_probe] && !resv_mask[rs_probe]) begin
                disp_ok  = 1'b1;
                disp_idx = rs_probe;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && !FLUSH && enq_fire) begin
            if (ENQ_VALID[0]) begin
                task_mem[tail] <= ENQ_TASK_0;
                cls_mem[tail]  <= to_cls(ENQ_CLASS_0);
            end
            if (ENQ_VALID[1]) begin
                task_mem[wr_ptr1] <= ENQ_TASK_1;
                cls_mem[wr_ptr1]  <= to_cls(ENQ_CLASS_1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            head       <= '0;
            tail       <= '0;
            COUNT      <= '0;
            FULL       <= 1'b0;
            DISP_VALID <= 1'b0;
            DISP_TASK  <= '0;
            DISP_RS    <= '0;
            resv_mask  <= '0;
        end else if (FLUSH) begin
            head       <= '0;
            tail       <= '0;
            COUNT      <= '0;
            FULL       <= 1'b0;
            DISP_VALID <= 1'b0;
            resv_mask  <= '0;
        end else begin
            tail       <= tail + PTR_W'(enq_n);
            if (disp_ok) begin
                head      <= head + PTR_W'(1);
                DISP_TASK <= task_mem[head];
                DISP_RS   <= disp_idx;
            end
            DISP_VALID <= disp_ok;
            resv_mask  <= disp_ok ? (N_TOT'(1) << disp_idx) : '0;
            COUNT      <= count_next;
            FULL       <= (count_next == CNT_W'(DEPTH));
        end
    end

`ifdef IQ_STALL_CNT_EN
    // A flush cycle is not a stall: the queue is being discarded, not blocked.
    always_ff @(posedge CLK) begin
        if (RST)
            STALL_CNT <= '0;
        else if (!FLUSH && (COUNT != '0) && !disp_ok && (STALL_CNT != '1))
            STALL_CNT <= STALL_CNT + 32'd1;
    end
`endif

endmodule

// File: tb/tb_issue_dispatch_queue.sv
// Self-checking bench for issue_dispatch_queue: directed plan steps plus random traffic against a queue model.
// Covers STALL_CNT when IQ_STALL_CNT_EN is defined.
module tb_issue_dispatch_queue;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        FLUSH = 1'b0;
    logic [1:0]  ENQ_VALID = '0;
    logic [63:0] ENQ_TASK_0 = '0, ENQ_TASK_1 = '0;
    logic [1:0]  ENQ_CLASS_0 = '0, ENQ_CLASS_1 = '0;
    logic        ENQ_READY;
    logic [5:0]  RS_BUSY = '0;
    logic        DISP_VALID;
    logic [63:0] DISP_TASK;
    logic [2:0]  DISP_RS;
    logic [4:0]  COUNT;
    logic        FULL;
`ifdef IQ_STALL_CNT_EN
    logic [31:0] STALL_CNT;
`endif

    issue_dispatch_queue #(.TASK_W(64), .DEPTH(16), .N_RS(2)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
        .ENQ_VALID(ENQ_VALID), .ENQ_TASK_0(ENQ_TASK_0), .ENQ_TASK_1(ENQ_TASK_1),
        .ENQ_CLASS_0(ENQ_CLASS_0), .ENQ_CLASS_1(ENQ_CLASS_1), .ENQ_READY(ENQ_READY),
        .RS_BUSY(RS_BUSY), .DISP_VALID(DISP_VALID), .DISP_TASK(DISP_TASK),
        .DISP_RS(DISP_RS), .COUNT(COUNT), .FULL(FULL)
`ifdef IQ_STALL_CNT_EN
        , .STALL_CNT(STALL_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [63:0] t; int c; } ent_t;
    ent_t        mq[$];
    int          prev_rs = -1;
    int          pops = 0;
    logic        exp_dv = 1'b0;
    logic [63:0] exp_task = '0;
    int          exp_rs = 0;
    logic [31:0] stall_exp = '0;
    int          errors = 0;
    int          checks = 0;
    logic [63:0] next_id = 64'h1000;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] new_id();
        next_id = next_id + 64'd1;
        return next_id;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ":disp_valid"}, 64'(DISP_VALID), 64'(exp_dv));
        check({tag, ":disp_task"},  DISP_TASK, exp_task);
        check({tag, ":disp_rs"},    64'(DISP_RS), 64'(exp_rs));
        check({tag, ":count"},      64'(COUNT), 64'(mq.size()));
        check({tag, ":full"},       64'(FULL), 64'(mq.size() == 16));
`ifdef IQ_STALL_CNT_EN
        check({tag, ":stall_cnt"},  64'(STALL_CNT), 64'(stall_exp));
`endif
    endtask

    task automatic step(input string tag, input logic fl, input logic [1:0] ev,
                        input logic [63:0] t0, input logic [1:0] c0,
                        input logic [63:0] t1, input logic [1:0] c1,
                        input logic [5:0] busy);
        int sz;
        bit rdy;
        int cls;
        int pick;
        @(negedge CLK);
        FLUSH = fl; ENQ_VALID = ev; ENQ_TASK_0 = t0; ENQ_TASK_1 = t1;
        ENQ_CLASS_0 = c0; ENQ_CLASS_1 = c1; RS_BUSY = busy;
        sz  = mq.size();
        rdy = (16 - sz) >= 2;
        #1 check({tag, ":enq_ready"}, 64'(ENQ_READY), 64'(rdy));
        pick = -1;
        if (fl) begin
            mq.delete();
            prev_rs = -1;
            exp_dv  = 1'b0;
            pops    = 0;
        end else begin
            if (sz > 0) begin
                cls = mq[0].c;
                for (int r = cls*2; r < cls*2 + 2; r++)
                    if (pick < 0 && !busy[r] && r != prev_rs) pick = r;
            end
            if (pick >= 0) begin
                exp_dv   = 1'b1;
                exp_task = mq[0].t;
                exp_rs   = pick;
                void'(mq.pop_front());
                pops++;
            end else begin
                exp_dv = 1'b0;
            end
            prev_rs = pick;
            if (rdy && ev != 2'b00) begin
                if (ev[0]) mq.push_back('{t0, (c0 == 2'd3) ? 0 : int'(c0)});
                if (ev[1]) mq.push_back('{t1, (c1 == 2'd3) ? 0 : int'(c1)});
            end
            if (sz > 0 && pick < 0 && stall_exp != 32'hFFFF_FFFF) stall_exp++;
        end
        @(posedge CLK);
        #1 check_outputs(tag);
    endtask

    task automatic idle(input string tag, input logic [5:0] busy);
        step(tag, 1'b0, 2'b00, '0, 2'd0, '0, 2'd0, busy);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; FLUSH = 1'b0; ENQ_VALID = '0; RS_BUSY = '0;
        repeat (2) @(posedge CLK);
        mq.delete(); prev_rs = -1; pops = 0;
        exp_dv = 1'b0; exp_task = '0; exp_rs = 0; stall_exp = '0;
        #1 check_outputs("reset");
        check("reset:enq_ready", 64'(ENQ_READY), 64'd1);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        logic [63:0] ta, tb;
        int guard;

        do_reset();

        // ALU A + LOAD B together, all RS idle
        ta = new_id(); tb = new_id();
        step("pair_enq", 1'b0, 2'b11, ta, 2'd0, tb, 2'd1, 6'b0);
        idle("pair_a", 6'b0);
        check("pair_a:task_const", DISP_TASK, ta);
        check("pair_a:rs_const", 64'(DISP_RS), 64'd0);
        idle("pair_b", 6'b0);
        check("pair_b:task_const", DISP_TASK, tb);
        check("pair_b:rs_const", 64'(DISP_RS), 64'd2);

        // Fill to 16 with everything busy, then a dropped 9th dual enqueue
        for (int i = 0; i < 8; i++) step("fill", 1'b0, 2'b11, new_id(), 2'd0, new_id(), 2'd1, 6'b111111);
        check("fill:count_const", 64'(COUNT), 64'd16);
        step("fill_drop", 1'b0, 2'b11, new_id(), 2'd2, new_id(), 2'd2, 6'b111111);
        check("fill_drop:count_const", 64'(COUNT), 64'd16);
        for (int i = 0; i < 20; i++) idle("drain", 6'b0);

        // Three ALU tasks: RS 0, 1, 0
        step("alu3_enq", 1'b0, 2'b11, new_id(), 2'd0, new_id(), 2'd3, 6'b0);
        step("alu3_a", 1'b0, 2'b01, new_id(), 2'd0, '0, 2'd0, 6'b0);
        check("alu3_a:rs_const", 64'(DISP_RS), 64'd0);
        idle("alu3_b", 6'b0);
        check("alu3_b:rs_const", 64'(DISP_RS), 64'd1);
        idle("alu3_c", 6'b0);
        check("alu3_c:rs_const", 64'(DISP_RS), 64'd0);

        // STORE head blocked by busy 4,5; ALU behind must not bypass
        ta = new_id(); tb = new_id();
        step("hol_enq", 1'b0, 2'b11, ta, 2'd2, tb, 2'd0, 6'b110000);
        for (int i = 0; i < 5; i++) idle("hol_stall", 6'b110000);
        idle("hol_store", 6'b010000);
        check("hol_store:rs_const", 64'(DISP_RS), 64'd5);
        idle("hol_alu", 6'b010000);
        check("hol_alu:task_const", DISP_TASK, tb);

        // Walk head pointer to 14, queue 7 entries, flush with a dual enqueue
        guard = 0;
        while (pops % 16 != 14 && guard < 64) begin
            if (mq.size() == 0) step("walk_enq", 1'b0, 2'b01, new_id(), 2'd1, '0, 2'd0, 6'b0);
            else idle("walk_disp", 6'b0);
            guard++;
        end
        while (mq.size() != 0 && guard < 64) begin
            idle("walk_empty", 6'b0);
            guard++;
        end
        for (int i = 0; i < 3; i++) step("wrap_fill", 1'b0, 2'b11, new_id(), 2'd0, new_id(), 2'd2, 6'b111111);
        step("wrap_fill1", 1'b0, 2'b10, '0, 2'd0, new_id(), 2'd1, 6'b111111);
        check("wrap:count_const", 64'(COUNT), 64'd7);
        step("flush", 1'b1, 2'b11, new_id(), 2'd0, new_id(), 2'd0, 6'b0);
        check("flush:count_const", 64'(COUNT), 64'd0);
        check("flush:ready_const", 64'(ENQ_READY), 64'd1);
        ta = new_id();
        step("post_flush_enq", 1'b0, 2'b01, ta, 2'd0, '0, 2'd0, 6'b0);
        idle("post_flush_disp", 6'b0);
        check("post_flush:task_const", DISP_TASK, ta);

`ifdef IQ_STALL_CNT_EN
        do_reset();
        step("stall_enq", 1'b0, 2'b01, new_id(), 2'd2, '0, 2'd0, 6'b110000);
        for (int i = 0; i < 10; i++) idle("stall", 6'b110000);
        check("stall:cnt_const", 64'(STALL_CNT), 64'd10);
        step("stall_flush", 1'b1, 2'b00, '0, 2'd0, '0, 2'd0, 6'b110000);
        check("stall_flush:cnt_const", 64'(STALL_CNT), 64'd10);
        do_reset();
        check("stall_rst:cnt_const", 64'(STALL_CNT), 64'd0);
`endif

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            step("rand", ($urandom_range(0, 31) == 0),
                 2'($urandom_range(0, 3)),
                 new_id(), 2'($urandom_range(0, 3)),
                 new_id(), 2'($urandom_range(0, 3)),
                 6'($urandom) | 6'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
